// File: rtl/inert_serf.sv
// Cycle-based SPI responder model of the inertial sensor: 16-bit frames,
// config registers, periodic sample snapshots and a data-ready interrupt.
module inert_serf #(
  parameter logic [15:0] DATA_PERIOD = 16'd2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] ptch_in,
  input  logic [15:0] roll_in,
  input  logic [15:0] yaw_in,
  input  logic [15:0] ax_in,
  input  logic [15:0] ay_in
);

  logic [2:0]  ss_sync_r;
  logic [2:0]  sclk_sync_r;
  logic [1:0]  mosi_sync_r;
  logic        ss_n_s;
  logic        mosi_s;
  logic        ss_fall_s;
  logic        ss_rise_s;
  logic        sclk_rise_s;
  logic        sclk_fall_s;

  logic [4:0]  bit_cnt_r;
  logic [15:0] rx_shft_r;
  logic [15:0] rx_next_s;
  logic [7:0]  tx_shft_r;
  logic        miso_r;
  logic        int_r;
  logic        rise8_s;
  logic [6:0]  addr_s;
  logic        is_read_s;
  logic [7:0]  rd_data_s;
  logic        frame_done_s;
  logic        wr_en_s;
  logic        int_clr_s;

  logic [7:0]  cfg_0d_r;
  logic [7:0]  cfg_10_r;
  logic [7:0]  cfg_11_r;
  logic [7:0]  cfg_14_r;
  logic [15:0] ptch_r;
  logic [15:0] roll_r;
  logic [15:0] yaw_r;
  logic [15:0] ax_r;
  logic [15:0] ay_r;

  logic [15:0] timer_r;
  logic        sample_due_r;
  logic        wrap_s;
  logic        snap_s;

  // Pin synchronizers; SS_n and SCLK idle high so they reset high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_r   <= 3'b111;
      sclk_sync_r <= 3'b111;
      mosi_sync_r <= 2'b00;
    end else begin
      ss_sync_r   <= {ss_sync_r[1:0], SS_n};
      sclk_sync_r <= {sclk_sync_r[1:0], SCLK};
      mosi_sync_r <= {mosi_sync_r[0], MOSI};
    end
  end

  assign ss_n_s      = ss_sync_r[1];
  assign mosi_s      = mosi_sync_r[1];
  assign ss_fall_s   = ss_sync_r[2] & ~ss_sync_r[1];
  assign ss_rise_s   = ~ss_sync_r[2] & ss_sync_r[1];
  assign sclk_rise_s = ~sclk_sync_r[2] & sclk_sync_r[1] & ~ss_n_s;
  assign sclk_fall_s = sclk_sync_r[2] & ~sclk_sync_r[1] & ~ss_n_s;

  assign rx_next_s    = {rx_shft_r[14:0], mosi_s};
  assign rise8_s      = sclk_rise_s & (bit_cnt_r == 5'd7);
  assign addr_s       = rx_next_s[6:0];
  assign is_read_s    = rx_next_s[7];
  assign frame_done_s = ss_rise_s & (bit_cnt_r == 5'd16);
  assign wr_en_s      = frame_done_s & ~rx_shft_r[15];
  assign int_clr_s    = frame_done_s & (rx_shft_r[15:8] == 8'hA2);

  // Receive shifter and bit counter; rises past the 16th are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= 5'd0;
      rx_shft_r <= 16'h0000;
    end else if (ss_fall_s) begin
      bit_cnt_r <= 5'd0;
      rx_shft_r <= 16'h0000;
    end else if (sclk_rise_s && (bit_cnt_r < 5'd16)) begin
      bit_cnt_r <= bit_cnt_r + 5'd1;
      rx_shft_r <= rx_next_s;
    end else begin
      bit_cnt_r <= bit_cnt_r;
      rx_shft_r <= rx_shft_r;
    end
  end

  // Register read mux; unmapped addresses read as zero.
  always_comb begin
    rd_data_s = 8'h00;
    case (addr_s)
      7'h0D:   rd_data_s = cfg_0d_r;
      7'h10:   rd_data_s = cfg_10_r;
      7'h11:   rd_data_s = cfg_11_r;
      7'h14:   rd_data_s = cfg_14_r;
      7'h22:   rd_data_s = ptch_r[7:0];
      7'h23:   rd_data_s = ptch_r[15:8];
      7'h24:   rd_data_s = roll_r[7:0];
      7'h25:   rd_data_s = roll_r[15:8];
      7'h26:   rd_data_s = yaw_r[7:0];
      7'h27:   rd_data_s = yaw_r[15:8];
      7'h28:   rd_data_s = ax_r[7:0];
      7'h29:   rd_data_s = ax_r[15:8];
      7'h2A:   rd_data_s = ay_r[7:0];
      7'h2B:   rd_data_s = ay_r[15:8];
      default: rd_data_s = 8'h00;
    endcase
  end

  // Response shifter: loaded at the 8th rise, one bit out per following fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft_r <= 8'h00;
      miso_r    <= 1'b0;
    end else if (ss_fall_s || ss_rise_s) begin
      tx_shft_r <= 8'h00;
      miso_r    <= 1'b0;
    end else if (rise8_s) begin
      tx_shft_r <= is_read_s ? rd_data_s : 8'h00;
      miso_r    <= miso_r;
    end else if (sclk_fall_s && (bit_cnt_r >= 5'd8) && (bit_cnt_r < 5'd16)) begin
      tx_shft_r <= {tx_shft_r[6:0], 1'b0};
      miso_r    <= tx_shft_r[7];
    end else begin
      tx_shft_r <= tx_shft_r;
      miso_r    <= miso_r;
    end
  end

  // Config register writes commit only when a complete write frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_0d_r <= 8'h00;
      cfg_10_r <= 8'h00;
      cfg_11_r <= 8'h00;
      cfg_14_r <= 8'h00;
    end else if (wr_en_s) begin
      case (rx_shft_r[14:8])
        7'h0D:   cfg_0d_r <= rx_shft_r[7:0];
        7'h10:   cfg_10_r <= rx_shft_r[7:0];
        7'h11:   cfg_11_r <= rx_shft_r[7:0];
        7'h14:   cfg_14_r <= rx_shft_r[7:0];
        default: cfg_0d_r <= cfg_0d_r;
      endcase
    end else begin
      cfg_0d_r <= cfg_0d_r;
    end
  end

  assign wrap_s = (timer_r == (DATA_PERIOD - 16'd1));
  // Snapshots wait for SS_n high so a frame never reads torn data.
  assign snap_s = sample_due_r & ss_n_s;

  // Sample period timer and pending-sample flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r      <= 16'd0;
      sample_due_r <= 1'b0;
    end else begin
      timer_r <= wrap_s ? 16'd0 : (timer_r + 16'd1);
      if (wrap_s) begin
        sample_due_r <= 1'b1;
      end else if (snap_s) begin
        sample_due_r <= 1'b0;
      end else begin
        sample_due_r <= sample_due_r;
      end
    end
  end

  // Data register snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_r <= 16'h0000;
      roll_r <= 16'h0000;
      yaw_r  <= 16'h0000;
      ax_r   <= 16'h0000;
      ay_r   <= 16'h0000;
    end else if (snap_s) begin
      ptch_r <= ptch_in;
      roll_r <= roll_in;
      yaw_r  <= yaw_in;
      ax_r   <= ax_in;
      ay_r   <= ay_in;
    end else begin
      ptch_r <= ptch_r;
      roll_r <= roll_r;
      yaw_r  <= yaw_r;
      ax_r   <= ax_r;
      ay_r   <= ay_r;
    end
  end

  // Data-ready interrupt; a new sample outranks the read-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_r <= 1'b0;
    end else if (snap_s && cfg_0d_r[1]) begin
      int_r <= 1'b1;
    end else if (int_clr_s) begin
      int_r <= 1'b0;
    end else begin
      int_r <= int_r;
    end
  end

  assign MISO = miso_r;
  assign INT  = int_r;

endmodule

// File: tb/tb_inert_serf.sv
// Directed bench for inert_serf: drives SPI frames as a master and checks
// register reads, write filtering, snapshot deferral and INT behaviour.
module tb_inert_serf;
  localparam logic [15:0] P = 16'd1000;
  localparam int H = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n = 1'b1;
  logic SCLK = 1'b1;
  logic MOSI = 1'b0;
  logic MISO;
  logic INT;
  logic [15:0] ptch_in = 16'h0000;
  logic [15:0] roll_in = 16'h0000;
  logic [15:0] yaw_in = 16'h0000;
  logic [15:0] ax_in = 16'h0000;
  logic [15:0] ay_in = 16'h0000;

  int tests = 0;
  int failed = 0;
  int cyc;
  logic [15:0] resp;
  logic [7:0] rdat;
  logic seen;

  inert_serf #(.DATA_PERIOD(P)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .ptch_in(ptch_in), .roll_in(roll_in),
    .yaw_in(yaw_in), .ax_in(ax_in), .ay_in(ay_in)
  );

  always #10 clk = ~clk;

  // Mirrors the sample timer phase: cycles since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int nrise, input bit raise_ss,
                           output logic [15:0] rsp);
    rsp = 16'h0000;
    SS_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15 - i];
      repeat (H) @(negedge clk);
      rsp = {rsp[14:0], MISO};
      SCLK = 1'b1;
      repeat (H) @(negedge clk);
    end
    if (raise_ss) begin
      SS_n = 1'b1;
      repeat (2 * H) @(negedge clk);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    logic [15:0] r;
    spi_frame({1'b0, a, d}, 16, 1'b1, r);
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    logic [15:0] r;
    spi_frame({1'b1, a, 8'h00}, 16, 1'b1, r);
    d = r[7:0];
  endtask

  task automatic wait_int(input int bound);
    for (int i = 0; i < bound && INT !== 1'b1; i++) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_int", {15'd0, INT}, 16'h0000);
    check("reset_miso", {15'd0, MISO}, 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Config writes and reads
    wr(7'h0D, 8'h02);
    spi_frame(16'h8D00, 16, 1'b1, resp);
    check("cfg_0d", resp, 16'h0002);
    wr(7'h10, 8'h62);
    rd(7'h10, rdat);
    check("cfg_10", {8'h00, rdat}, 16'h0062);
    wr(7'h11, 8'h55);
    rd(7'h11, rdat);
    check("cfg_11", {8'h00, rdat}, 16'h0055);
    wr(7'h14, 8'hAA);
    rd(7'h14, rdat);
    check("cfg_14", {8'h00, rdat}, 16'h00AA);
    wr(7'h12, 8'h99);
    rd(7'h12, rdat);
    check("unmapped_12", {8'h00, rdat}, 16'h0000);
    wr(7'h22, 8'h77);
    rd(7'h22, rdat);
    check("ro_22", {8'h00, rdat}, 16'h0000);
    check("idle_miso", {15'd0, MISO}, 16'h0000);

    // Aborted write frame leaves the register alone
    wr(7'h10, 8'h33);
    spi_frame(16'h1062, 8, 1'b1, resp);
    rd(7'h10, rdat);
    check("abort_keep_10", {8'h00, rdat}, 16'h0033);

    // INT disabled: data still updates
    wr(7'h0D, 8'h00);
    yaw_in = 16'h00FF;
    rd(7'h22, rdat);
    check("int_cleared", {15'd0, INT}, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 3 * int'(P); i++) begin
      @(negedge clk);
      seen = seen | INT;
    end
    check("int_disabled", {15'd0, seen}, 16'h0000);
    rd(7'h26, rdat);
    check("yaw_l", {8'h00, rdat}, 16'h00FF);
    rd(7'h27, rdat);
    check("yaw_h", {8'h00, rdat}, 16'h0000);

    // Data ready with INT enabled
    ptch_in = 16'h1234;
    ay_in   = 16'hBEEF;
    wr(7'h0D, 8'h02);
    wait_int(2 * int'(P));
    check("int_rise", {15'd0, INT}, 16'h0001);
    check("int_phase", 16'(cyc % int'(P)), 16'h0001);
    rd(7'h22, rdat);
    check("ptch_l", {8'h00, rdat}, 16'h0034);
    check("int_fall", {15'd0, INT}, 16'h0000);
    rd(7'h23, rdat);
    check("ptch_h", {8'h00, rdat}, 16'h0012);
    rd(7'h2A, rdat);
    check("ay_l", {8'h00, rdat}, 16'h00EF);
    rd(7'h2B, rdat);
    check("ay_h", {8'h00, rdat}, 16'h00BE);

    // Deferred snapshot: frame starts 4 cycles before the wrap
    for (int i = 0; i < 2 * int'(P) && (cyc % int'(P)) != int'(P) - 4; i++) @(negedge clk);
    check("defer_align", 16'(cyc % int'(P)), P - 16'd4);
    ptch_in = 16'h5678;
    spi_frame(16'hA200, 16, 1'b1, resp);
    check("defer_old", resp, 16'h0034);
    check("int_set_wins", {15'd0, INT}, 16'h0001);
    rd(7'h22, rdat);
    check("defer_new", {8'h00, rdat}, 16'h0078);
    check("int_clr2", {15'd0, INT}, 16'h0000);

    // Reset in the middle of a read frame
    wait_int(2 * int'(P));
    spi_frame(16'h8D00, 15, 1'b0, resp);
    check("pre_rst_miso", {15'd0, MISO}, 16'h0001);
    check("pre_rst_int", {15'd0, INT}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("rst_int_now", {15'd0, INT}, 16'h0000);
    check("rst_miso_now", {15'd0, MISO}, 16'h0000);
    SS_n = 1'b1;
    SCLK = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd(7'h0D, rdat);
    check("post_rst_0d", {8'h00, rdat}, 16'h0000);
    rd(7'h10, rdat);
    check("post_rst_10", {8'h00, rdat}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/inert_serf.md
# inert_serf

Cycle-based SPI responder model of the inertial sensor. It answers 16-bit SPI frames from the master-side inertial interface, holds the sensor configuration registers, snapshots pitch/roll/yaw-rate and AX/AY samples at a fixed period, and raises INT when a new sample is ready. It is used in full-chip simulation and as the DUT stimulus source for the inertial interface bench.

## Interface
Parameters:
- DATA_PERIOD, default 16'd2048: number of clk cycles between sample snapshots; legal range 2..65535.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- SS_n  in  1  SPI serf select, active low.
- SCLK  in  1  SPI clock, idles high.
- MOSI  in  1  SPI data from the master, MSB first.
- MISO  out  1  SPI data to the master, MSB first.
- INT  out  1  data-ready interrupt, active high.
- ptch_in, roll_in, yaw_in  in  16 each  rate samples presented by the bench.
- ax_in, ay_in  in  16 each  acceleration samples presented by the bench.

## Operation
- Synchronizers: SS_n, SCLK and MOSI each pass through 2 flops. A third SCLK flop provides rise and fall detection. SS_n fall and rise are detected the same way.
- Frame: SS_n fall clears bit_cnt (5 bits) and rx_shft (16 bits). Each detected SCLK rise shifts synchronized MOSI into rx_shft LSB and increments bit_cnt. Rises after the 16th are ignored.
- Command format: bit15 selects read (1) or write (0), bits14:8 are addr, bits7:0 are write data.
- Read path: at the 8th rise, addr = rx_shft[6:0]. tx_shft[7:0] is loaded with reg[addr], or 0x00 for an unmapped address. MISO is 0 for frame bits 15:8. On each SCLK fall after the 8th rise, MISO takes the next tx_shft bit, MSB first.
- Write path: commits on SS_n rise only if bit_cnt==16 and bit15==0.
  - Writable config registers: 0x0D, 0x10, 0x11, 0x14. Each is 8 bits and resets to 0x00.
  - Writes to any other address are dropped.
- Data registers, read-only: 0x22/0x23 ptch L/H, 0x24/0x25 roll L/H, 0x26/0x27 yaw L/H, 0x28/0x29 AX L/H, 0x2A/0x2B AY L/H.
- Sample timer: a 16-bit counter counts 0..DATA_PERIOD-1 and wraps. At wrap, sample_due is set.
- Snapshot: when sample_due is set and SS_n (synchronized) is high, all five inputs are latched into the data registers and sample_due is cleared.
  - A due sample arriving mid-frame is deferred until the frame ends, so a frame never sees torn data.
- INT:
  - Set on a snapshot when reg 0x0D bit1 is 1.
  - Cleared on SS_n rise that ends a complete 16-bit read of 0x22.
  - Overrun (a snapshot while INT is already high) overwrites the data; INT stays high.
  - If 0x0D bit1 is 0, data still updates and INT stays 0.
- Aborted frame (SS_n rises with bit_cnt<16): no write commit, no INT clear. The next SS_n fall restarts cleanly.
- Simultaneous events: if INT set and INT clear occur in the same cycle, set wins.

## Timing
- Reset values: MISO=0, INT=0, all registers 0x00, timer=0, sample_due=0, bit_cnt=0.
- Input latency: 2 clk cycles from pin to synchronized value; edge detect 1 cycle later.
- MISO updates 3–4 clk cycles after the SCLK fall at the pin. This meets the master's sample point on the following rise for any SCLK half-period of 8 clk cycles or more.
- INT rises 1 cycle after the snapshot cycle. First INT (enabled from reset) occurs at cycle DATA_PERIOD+1 or 2.
- INT falls 1 cycle after SS_n rise is detected.
- MISO returns to 0 on SS_n rise detection.
- Reset mid-frame: everything returns to reset values immediately. Any partial frame is discarded.

## Test plan
- Reset: assert rst_n=0 mid-frame -> INT=0 and MISO=0 immediately; a read of 0x8D after release returns 0x00.
- Config write/read: frame 0x0D02, then frame 0x8Dxx -> response bits[7:0]=0x02. Frame 0x1062 then 0x90xx -> 0x62. Frame 0x2277 (write to a data register) -> a later read of 0xA2 is unchanged.
- Data ready: with 0x0D=0x02 and ptch_in=16'h1234, ay_in=16'hBEEF -> INT=1 after DATA_PERIOD cycles. Reads of 0xA2 and 0xA3 return 0x34 and 0x12; 0xAA and 0xAB return 0xEF and 0xBE. INT falls after the 0xA2 frame ends.
- INT disabled: 0x0D=0x00 and yaw_in=16'h00FF -> INT stays 0 for 3 periods; a read of 0xA6 returns 0xFF.
- Deferred snapshot: start a 0xA2 read 4 cycles before the timer wrap, with old value 0x34 and new ptch_in=16'h5678 -> the frame returns 0x34. The snapshot occurs on SS_n rise, and the next 0xA2 read returns 0x78.
- Aborted frame: SS_n rises after 8 SCLK rises of 0x1062 -> reg 0x10 unchanged. The next full frame 0x90xx returns the prior value.
